can_frame_tx: RTL and testbench
===============================

// Module: can_frame_tx
// PURPOSE
//  Serialises one CAN 2.0A standard data/remote frame onto a single-wire bit stream, one bit per clk.
//  Adds SOF, control field, CRC-15, delimiters, EOF and IFS, with bit stuffing; samples the ACK slot via rx_data.
//  Sits between the controller datapath and the PHY bus model; tx_data feeds the PHY, rx_data is the bus readback.
// PARAMETERS
//  EOF_BITS   7   recessive EOF bits after ACK delimiter
//  IFS_BITS   3   recessive intermission bits before tx_ready returns
//  MAX_BYTES  8   data bytes sent when dlc > 8 (CAN clamp)
// PORTS
//  clk        in   1   bit clock; one CAN bit per rising edge
//  rst_n      in   1   synchronous reset, active low
//  tx_valid   in   1   frame request
//  tx_ready   out  1   block idle, can accept a frame
//  tx_id      in   11  identifier, MSB sent first
//  tx_rtr     in   1   1 = remote frame (no data field)
//  tx_dlc     in   4   data length code
//  tx_payload in   64  data; byte 0 = [63:56], sent MSB first
//  rx_data    in   1   bus readback (0 = dominant)
//  tx_data    out  1   serial bit to PHY (1 = recessive), registered
//  busy       out  1   frame in progress (accept through IFS)
//  done       out  1   1-cycle pulse at end of IFS
//  ack_err    out  1   1-cycle pulse with done when ACK slot read recessive
//  arb_lost   out  1   1-cycle pulse on arbitration loss (CAN_TX_ARB_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): tx_data=1, tx_ready=1, busy=0, done=0, ack_err=0, arb_lost=0, state IDLE,
//    all counters/CRC cleared. Reset mid-frame aborts immediately; no done/ack_err pulse.
//  - Handshake: accept when tx_valid&&tx_ready at clk edge; latch all tx_* fields; tx_ready drops same edge.
//    tx_* may change after accept. SOF (0) appears on tx_data the cycle after accept.
//  - States: IDLE -> SOF -> ID(11) -> RTR -> IDE(0) -> R0(0) -> DLC(4) -> DATA(0..64) -> CRC(15) -> CRC_DEL(1)
//    -> ACK(1, drive 1) -> ACK_DEL(1) -> EOF(EOF_BITS x 1) -> IFS(IFS_BITS x 1) -> IDLE.
//  - DATA length = 0 if rtr=1, else 8*min(dlc, MAX_BYTES); DATA skipped when length 0. DLC sent as given.
//  - CRC-15, poly 0x4599, init 0, over unstuffed SOF..last data bit; CRC sent MSB first.
//  - Stuffing SOF..last CRC bit: after 5 equal consecutive emitted bits (stuff bits count), emit complement;
//    field counters and CRC hold during stuff cycle. Stuff check also runs after the final CRC bit
//    (stuff bit allowed before CRC_DEL). No stuffing from CRC_DEL onward.
//  - ACK: sample rx_data at edge ending the ACK bit cycle; 1 -> ack_err asserted with done.
//  - done on last IFS cycle edge; tx_ready=1 and busy=0 from next cycle. New accept possible that cycle.
//  - tx_valid while busy is ignored (not queued).
// CONFIGURATION
//  CAN_TX_ARB_EN defined: during ID and RTR bits (incl. their stuff bits) compare rx_data to tx_data at bit end;
//    tx_data=1 && rx_data=0 -> arb_lost pulse, tx_data=1 next cycle, return to IDLE (no done, no IFS).
//  Undefined: no comparison; arb_lost constant 0; frame always runs to completion.
// STRUCTURE
//  can_pkg: state enum, CRC15_POLY=15'h4599, field widths (ID_W=11, DLC_W=4, CRC_W=15), STUFF_LIMIT=5.
//  Sub-module can_crc15: serial CRC register (clk, rst_n, clear, en, bit_in, crc[14:0]).
//  Top: FSM, field bit counter, stuff counter/last-bit register, payload shift register.
// TESTING
//  1 id=0x123 rtr=0 dlc=2 payload=0xABCD<<48, PHY pulls ACK low -> unstuffed stream matches golden incl. CRC;
//    done=1, ack_err=0; busy high accept+1 .. done.
//  2 id=0x000 dlc=0 -> tx_data 0,0,0,0,0 then stuff 1 at cycle 6 after accept; total frame length matches golden.
//  3 rtr=1 dlc=4 -> no data bits; DLC field 0100; CRC over 19 bits matches golden.
//  4 dlc=15 payload=0x0123456789ABCDEF -> 64 data bits; DLC field sent as 1111.
//  5 rx_data=tx_data loopback (no ACK) -> ack_err=1 with done; reset asserted at DATA bit 10 -> tx_data=1 next cycle, no done.
//  6 CAN_TX_ARB_EN, id=0x7FF, force rx_data=0 at ID bit 3 -> arb_lost pulse, tx_ready=1 next cycle; macro off -> frame completes.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN 2.0A frame transmitter.
package can_pkg;

    localparam int ID_W        = 11;
    localparam int DLC_W       = 4;
    localparam int CRC_W       = 15;
    localparam int STUFF_LIMIT = 5;

    localparam logic [CRC_W-1:0] CRC15_POLY = 15'h4599;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ID,
        ST_RTR,
        ST_IDE,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } state_t;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register: one unstuffed bit per enabled clock, MSB-first feedback.
module can_crc15
    import can_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[CRC_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC15_POLY : '0);
        end
    end

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A standard-frame serialiser with bit stuffing, CRC-15 and ACK check.
// Define CAN_TX_ARB_EN to enable arbitration-loss detection during ID/RTR.
module can_frame_tx
    import can_pkg::*;
#(
    parameter int EOF_BITS  = 7,
    parameter int IFS_BITS  = 3,
    parameter int MAX_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [ID_W-1:0]   tx_id,
    input  logic              tx_rtr,
    input  logic [DLC_W-1:0]  tx_dlc,
    input  logic [63:0]       tx_payload,
    input  logic              rx_data,
    output logic              tx_data,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic              arb_lost
);

    state_t            state, adv_state;
    logic [6:0]        bit_cnt, adv_cnt, data_len;
    logic [2:0]        stuff_cnt;
    logic              last_bit, adv_bit;
    logic              crc_en, shift_id, shift_dlc, shift_data;
    logic [ID_W-1:0]   id_sr;
    logic              rtr_r;
    logic [DLC_W-1:0]  dlc_sr;
    logic [63:0]       data_sr;
    logic [CRC_W-1:0]  crc_val;
    logic [3:0]        n_bytes;
    logic              ack_miss, stuff_now, arb_hit, frame_end;

    assign n_bytes   = (tx_dlc > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : tx_dlc;
    assign stuff_now = (state inside {ST_SOF, ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA, ST_CRC})
                       && (stuff_cnt == 3'(STUFF_LIMIT));
    assign frame_end = (state == ST_IFS) && (bit_cnt == 7'(IFS_BITS - 1));

`ifdef CAN_TX_ARB_EN
    assign arb_hit = (state == ST_ID || state == ST_RTR) && tx_data && !rx_data;
`else
    assign arb_hit = 1'b0;
`endif

    // SOF is a 0 into a cleared register, so skipping it leaves the CRC unchanged.
    can_crc15 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_IDLE),
        .en     (crc_en && !stuff_now && !arb_hit && state != ST_IDLE),
        .bit_in (adv_bit),
        .crc    (crc_val)
    );

    // Position and value of the next unstuffed bit, given the bit now on the wire.
    always_comb begin
        adv_state  = state;
        adv_cnt    = bit_cnt + 7'd1;
        adv_bit    = 1'b1;
        crc_en     = 1'b0;
        shift_id   = 1'b0;
        shift_dlc  = 1'b0;
        shift_data = 1'b0;
        case (state)
            ST_SOF: begin
                adv_state = ST_ID;
                adv_cnt   = '0;
                adv_bit   = id_sr[ID_W-1];
                shift_id  = 1'b1;
                crc_en    = 1'b1;
            end
            ST_ID: begin
                crc_en = 1'b1;
                if (bit_cnt == 7'(ID_W - 1)) begin
                    adv_state = ST_RTR;
                    adv_cnt   = '0;
                    adv_bit   = rtr_r;
                end else begin
                    adv_bit  = id_sr[ID_W-1];
                    shift_id = 1'b1;
                end
            end
            ST_RTR: begin
                adv_state = ST_IDE;
                adv_bit   = 1'b0;
                crc_en    = 1'b1;
            end
            ST_IDE: begin
                adv_state = ST_R0;
                adv_bit   = 1'b0;
                crc_en    = 1'b1;
            end
            ST_R0: begin
                adv_state = ST_DLC;
                adv_cnt   = '0;
                adv_bit   = dlc_sr[DLC_W-1];
                shift_dlc = 1'b1;
                crc_en    = 1'b1;
            end
            ST_DLC: begin
                if (bit_cnt == 7'(DLC_W - 1)) begin
                    adv_cnt = '0;
                    if (data_len != 7'd0) begin
                        adv_state  = ST_DATA;
                        adv_bit    = data_sr[63];
                        shift_data = 1'b1;
                        crc_en     = 1'b1;
                    end else begin
                        adv_state = ST_CRC;
                        adv_bit   = crc_val[CRC_W-1];
                    end
                end else begin
                    adv_bit   = dlc_sr[DLC_W-1];
                    shift_dlc = 1'b1;
                    crc_en    = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_cnt == data_len - 7'd1) begin
                    adv_state = ST_CRC;
                    adv_cnt   = '0;
                    adv_bit   = crc_val[CRC_W-1];
                end else begin
                    adv_bit    = data_sr[63];
                    shift_data = 1'b1;
                    crc_en     = 1'b1;
                end
            end
            ST_CRC: begin
                if (bit_cnt == 7'(CRC_W - 1)) begin
                    adv_state = ST_CRC_DEL;
                    adv_cnt   = '0;
                end else begin
                    adv_bit = crc_val[4'd13 - bit_cnt[3:0]];
                end
            end
            ST_CRC_DEL: adv_state = ST_ACK;
            ST_ACK:     adv_state = ST_ACK_DEL;
            ST_ACK_DEL: begin
                adv_state = ST_EOF;
                adv_cnt   = '0;
            end
            ST_EOF: begin
                if (bit_cnt == 7'(EOF_BITS - 1)) begin
                    adv_state = ST_IFS;
                    adv_cnt   = '0;
                end
            end
            ST_IFS: begin
                if (frame_end) begin
                    adv_state = ST_IDLE;
                    adv_cnt   = '0;
                end
            end
            default: adv_cnt = bit_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            stuff_cnt <= '0;
            last_bit  <= 1'b1;
            id_sr     <= '0;
            rtr_r     <= 1'b0;
            dlc_sr    <= '0;
            data_sr   <= '0;
            data_len  <= '0;
            ack_miss  <= 1'b0;
            tx_data   <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            arb_lost  <= 1'b0;
        end else begin
            done     <= 1'b0;
            ack_err  <= 1'b0;
            arb_lost <= 1'b0;
            if (state == ST_IDLE) begin
                if (tx_valid) begin
                    state     <= ST_SOF;
                    bit_cnt   <= '0;
                    id_sr     <= tx_id;
                    rtr_r     <= tx_rtr;
                    dlc_sr    <= tx_dlc;
                    data_sr   <= tx_payload;
                    data_len  <= tx_rtr ? 7'd0 : {n_bytes, 3'b000};
                    tx_data   <= 1'b0;
                    last_bit  <= 1'b0;
                    stuff_cnt <= 3'd1;
                    tx_ready  <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (arb_hit) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                tx_data  <= 1'b1;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                arb_lost <= 1'b1;
            end else if (stuff_now) begin
                tx_data   <= ~last_bit;
                last_bit  <= ~last_bit;
                stuff_cnt <= 3'd1;
            end else begin
                state     <= adv_state;
                bit_cnt   <= adv_cnt;
                tx_data   <= adv_bit;
                last_bit  <= adv_bit;
                stuff_cnt <= (adv_bit == last_bit) ? stuff_cnt + 3'd1 : 3'd1;
                if (shift_id)   id_sr   <= {id_sr[ID_W-2:0], 1'b0};
                if (shift_dlc)  dlc_sr  <= {dlc_sr[DLC_W-2:0], 1'b0};
                if (shift_data) data_sr <= {data_sr[62:0], 1'b0};
                if (state == ST_ACK) ack_miss <= rx_data;
                if (frame_end) begin
                    done     <= 1'b1;
                    ack_err  <= ack_miss;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: golden frames, hand-computed fields, ACK, reset abort and arbitration.
module tb_can_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [10:0] tx_id = '0;
    logic        tx_rtr = 1'b0;
    logic [3:0]  tx_dlc = '0;
    logic [63:0] tx_payload = '0;
    logic        rx_data = 1'b1;
    logic        tx_data;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic        arb_lost;

    int n_checks = 0;
    int n_fail   = 0;

    logic uns[$];
    logic gold[$];
    logic cap[$];
    logic ds[$];
    int   ack_idx;
    int   data10_idx;
    logic seen_done, seen_arb, aborted, busy_ok, ready_low_ok, done_ack_err;
    logic arb_ready, arb_tx, arb_busy;
    int   arb_idx;

    always #5 clk = ~clk;

    can_frame_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_id      (tx_id),
        .tx_rtr     (tx_rtr),
        .tx_dlc     (tx_dlc),
        .tx_payload (tx_payload),
        .rx_data    (rx_data),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .arb_lost   (arb_lost)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: unstuffed fields + CRC, then stuffed, then fixed recessive tail.
    task automatic buildGolden(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] pl);
        logic [14:0] crc;
        logic        fb, last;
        int          nbits, cnt;
        uns.delete();
        gold.delete();
        uns.push_back(1'b0);
        for (int i = 10; i >= 0; i--) uns.push_back(id[i]);
        uns.push_back(rtr);
        uns.push_back(1'b0);
        uns.push_back(1'b0);
        for (int i = 3; i >= 0; i--) uns.push_back(dlc[i]);
        nbits = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nbits; i++) uns.push_back(pl[63-i]);
        crc = '0;
        foreach (uns[i]) begin
            fb  = uns[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) uns.push_back(crc[i]);
        cnt = 0;
        last = 1'b1;
        data10_idx = -1;
        foreach (uns[i]) begin
            if (i == 29) data10_idx = gold.size();
            gold.push_back(uns[i]);
            if (uns[i] == last) cnt++;
            else begin
                cnt  = 1;
                last = uns[i];
            end
            if (cnt == 5) begin
                gold.push_back(~last);
                last = ~last;
                cnt  = 1;
            end
        end
        gold.push_back(1'b1);
        ack_idx = gold.size();
        gold.push_back(1'b1);
        gold.push_back(1'b1);
        repeat (10) gold.push_back(1'b1);
    endtask

    task automatic destuffCapture();
        int   cnt;
        logic last, skip;
        ds.delete();
        cnt = 0;
        last = 1'b1;
        skip = 1'b0;
        foreach (cap[i]) begin
            if (skip) begin
                skip = 1'b0;
                last = cap[i];
                cnt  = 1;
            end else begin
                ds.push_back(cap[i]);
                if (cap[i] == last) cnt++;
                else begin
                    cnt  = 1;
                    last = cap[i];
                end
                if (cnt == 5) skip = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] dsBits(input int start, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], (start + i < ds.size()) ? ds[start+i] : 1'bx};
        return r;
    endfunction

    function automatic int streamErrors();
        int bad = 0;
        foreach (gold[i]) if (i >= cap.size() || cap[i] !== gold[i]) bad++;
        return bad;
    endfunction

    // Sends one frame and records tx_data until done, arb_lost, a planned reset, or a cycle budget.
    task automatic applyStimulus(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                 input logic [63:0] pl, input bit pull_ack, input int force_idx,
                                 input int reset_idx);
        int idx;
        cap.delete();
        seen_done = 0; seen_arb = 0; aborted = 0; busy_ok = 1; ready_low_ok = 1; done_ack_err = 1'bx;
        tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_payload = pl; tx_valid = 1'b1; rx_data = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_id = ~id; tx_rtr = ~rtr; tx_dlc = ~dlc; tx_payload = ~pl;
        idx = 0;
        while (!seen_done && !seen_arb && !aborted && idx < 400) begin
            if (done === 1'b1) begin
                seen_done    = 1;
                done_ack_err = ack_err;
            end else if (arb_lost === 1'b1) begin
                seen_arb  = 1;
                arb_idx   = idx;
                arb_ready = tx_ready;
                arb_tx    = tx_data;
                arb_busy  = busy;
            end else begin
                cap.push_back(tx_data);
                if (busy !== 1'b1) busy_ok = 0;
                if (tx_ready !== 1'b0) ready_low_ok = 0;
                if (idx == force_idx) rx_data = 1'b0;
                else if (pull_ack && idx == ack_idx) rx_data = 1'b0;
                else rx_data = tx_data;
                if (idx == reset_idx) rst_n = 1'b0;
                idx++;
                @(posedge clk); #1;
                if (rst_n == 1'b0) aborted = 1;
            end
        end
        rx_data = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] pl1;
        int          quiet_done;
        pl1 = 64'hABCD_0000_0000_0000;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst tx_data", tx_data, 1);
        checkOutput("rst tx_ready", tx_ready, 1);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst ack_err", ack_err, 0);
        checkOutput("rst arb_lost", arb_lost, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] frame 1: id 0x123 dlc 2 acked");
        buildGolden(11'h123, 1'b0, 4'd2, pl1);
        applyStimulus(11'h123, 1'b0, 4'd2, pl1, 1, -1, -1);
        checkOutput("t1 done seen", seen_done, 1);
        checkOutput("t1 length", cap.size(), gold.size());
        checkOutput("t1 stream errors", streamErrors(), 0);
        checkOutput("t1 ack_err", done_ack_err, 0);
        checkOutput("t1 busy during frame", busy_ok, 1);
        checkOutput("t1 ready low during frame", ready_low_ok, 1);
        checkOutput("t1 busy at done", busy, 0);
        checkOutput("t1 ready at done", tx_ready, 1);
        @(posedge clk); #1;
        checkOutput("t1 done one cycle", done, 0);

        $display("[TB] frame 2: id 0 dlc 0");
        buildGolden(11'h000, 1'b0, 4'd0, 64'h0);
        applyStimulus(11'h000, 1'b0, 4'd0, 64'h0, 1, -1, -1);
        checkOutput("t2 first six bits", {58'h0, cap[0], cap[1], cap[2], cap[3], cap[4], cap[5]},
                    64'b000001);
        checkOutput("t2 length", cap.size(), 53);
        checkOutput("t2 stream errors", streamErrors(), 0);
        checkOutput("t2 ack_err", done_ack_err, 0);

        $display("[TB] frame 3: remote frame dlc 4");
        buildGolden(11'h000, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(11'h000, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1, -1);
        destuffCapture();
        checkOutput("t3 rtr bit", dsBits(12, 1), 1);
        checkOutput("t3 dlc field", dsBits(15, 4), 4'b0100);
        checkOutput("t3 crc field", dsBits(19, 15), 15'h2B0A);
        checkOutput("t3 length", cap.size(), gold.size());
        checkOutput("t3 stream errors", streamErrors(), 0);

        $display("[TB] frame 4: dlc 15 clamps to 8 bytes");
        buildGolden(11'h2A5, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF);
        applyStimulus(11'h2A5, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 1, -1, -1);
        destuffCapture();
        checkOutput("t4 dlc field", dsBits(15, 4), 4'b1111);
        checkOutput("t4 data field", dsBits(19, 64), 64'h0123_4567_89AB_CDEF);
        checkOutput("t4 length", cap.size(), gold.size());
        checkOutput("t4 stream errors", streamErrors(), 0);

        $display("[TB] frame 5a: no ACK on the bus");
        buildGolden(11'h123, 1'b0, 4'd2, pl1);
        applyStimulus(11'h123, 1'b0, 4'd2, pl1, 0, -1, -1);
        checkOutput("t5 done seen", seen_done, 1);
        checkOutput("t5 ack_err with done", done_ack_err, 1);
        checkOutput("t5 stream errors", streamErrors(), 0);
        @(posedge clk); #1;
        checkOutput("t5 ack_err one cycle", ack_err, 0);

        $display("[TB] frame 5b: reset at data bit 10");
        buildGolden(11'h123, 1'b0, 4'd2, pl1);
        applyStimulus(11'h123, 1'b0, 4'd2, pl1, 1, -1, data10_idx);
        checkOutput("t5 reset reached", aborted, 1);
        checkOutput("t5 bits before reset", streamErrors() - (gold.size() - cap.size()), 0);
        checkOutput("t5 tx_data after reset", tx_data, 1);
        checkOutput("t5 busy after reset", busy, 0);
        checkOutput("t5 ready after reset", tx_ready, 1);
        checkOutput("t5 done after reset", done, 0);
        rst_n = 1'b1;
        quiet_done = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ack_err !== 1'b0 || tx_data !== 1'b1) quiet_done++;
        end
        checkOutput("t5 idle after abort", quiet_done, 0);

        $display("[TB] frame 6: id 0x7FF, bus dominant at ID bit 3");
        buildGolden(11'h7FF, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
        applyStimulus(11'h7FF, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1, 4, -1);
`ifdef CAN_TX_ARB_EN
        checkOutput("t6 arb_lost seen", seen_arb, 1);
        checkOutput("t6 arb cycle", arb_idx, 5);
        checkOutput("t6 ready after arb", arb_ready, 1);
        checkOutput("t6 tx_data after arb", arb_tx, 1);
        checkOutput("t6 busy after arb", arb_busy, 0);
        checkOutput("t6 no done", seen_done, 0);
        @(posedge clk); #1;
        checkOutput("t6 arb_lost one cycle", arb_lost, 0);
`else
        checkOutput("t6 no arb_lost", seen_arb, 0);
        checkOutput("t6 done seen", seen_done, 1);
        checkOutput("t6 stream errors", streamErrors(), 0);
        checkOutput("t6 ack_err", done_ack_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
